// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// In-order imem requests, PC+instr FIFO, redirect flush.
module instr_prefetch_queue #(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             out_valid,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_instr,
    input  logic             out_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SW = $clog2(DEPTH + MAX_OUT + 1) + 1;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  fifo_pc  [DEPTH];
    logic [INS_W-1:0] fifo_ins [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [OW-1:0]    out_cnt;
    logic [OW-1:0]    drop_cnt;
    logic [PC_W-1:0]  pend_pc  [MAX_OUT];
    logic [PW-1:0]    pend_rd;
    logic [PW-1:0]    pend_wr;
    logic [SW-1:0]    inflight;
    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] pnext(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);

    // Credit check and per-cycle event decode
    always_comb begin
        inflight = SW'(count) + SW'(out_cnt) - SW'(drop_cnt);
        imem_req = reset && !redirect
                && (out_cnt < OW'(MAX_OUT))
                && (inflight < SW'(DEPTH));
        issue    = imem_req && imem_ready;
        resp     = imem_rvalid && (out_cnt != '0);
        push     = resp && (drop_cnt == '0) && !redirect;
        pop      = out_valid && out_ready && !redirect;
    end

    // Head entry, zeroed when the queue is empty
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = fifo_pc[rd_ptr];
            out_instr = fifo_ins[rd_ptr];
        end
    end

    // Control state: fetch PC, pointers, counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
            pend_rd  <= '0;
            pend_wr  <= '0;
        end else begin
            if (issue)
                pend_wr <= pnext(pend_wr);
            if (resp)
                pend_rd <= pnext(pend_rd);
            out_cnt <= out_cnt + OW'(issue) - OW'(resp);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= out_cnt - OW'(resp);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + PC_W'(4);
                if (resp && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - OW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage: pending addresses and buffered instructions
    always_ff @(posedge clk) begin
        if (issue)
            pend_pc[pend_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]  <= pend_pc[pend_rd];
            fifo_ins[wr_ptr] <= imem_rdata;
        end
    end

endmodule
